seven_segment_reader: RTL

Recovers hex digit values from a multiplexed, active-low seven-segment drive (digit select plus shared segment bus) as produced by the team's segment formatter and display scanner. It sits on the display side of the design as a monitor/loopback checker: it debounces each segment/digit combination, decodes the pattern back to a 4-bit value per digit, and flags patterns that no formatter output can produce. Used for self-test and for exporting displayed values to other logic.

---
 rtl/seven_segment_reader_if.sv | 33 +++
 rtl/seven_segment_reader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader_if.sv
// Display-side bundle for seven_segment_reader: the scanned segment drive coming in
// and the recovered per-digit values and event pulses going out.
interface seven_segment_reader_if #(
  parameter int unsigned DIGITS = 6
);
  logic [DIGITS-1:0]   digit_sel;
  logic [6:0]          segments;
  logic [4*DIGITS-1:0] values;
  logic [DIGITS-1:0]   valid;
  logic                update;
  logic                error;
  logic [2:0]          error_digit;

  modport master (
    output digit_sel,
    output segments,
    input  values,
    input  valid,
    input  update,
    input  error,
    input  error_digit
  );

  modport slave (
    input  digit_sel,
    input  segments,
    output values,
    output valid,
    output update,
    output error,
    output error_digit
  );
endinterface

// File: rtl/seven_segment_reader.sv
// Monitors a multiplexed active-low seven-segment drive, debounces each digit/segment
// combination and decodes it back to a hex value per digit, flagging impossible patterns.
module seven_segment_reader #(
  parameter int unsigned DIGITS        = 6,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  seven_segment_reader_if.slave disp_io
);

  localparam int unsigned    CntW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StSettling,
    StCommitted
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DIGITS-1:0]   samp_sel_q;
  logic [6:0]          samp_seg_q;
  logic [4*DIGITS-1:0] values_q, values_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic                update_q, update_d;
  logic                error_q, error_d;
  logic [2:0]          error_digit_q, error_digit_d;

  logic       sel_onehot;
  logic       same_sample;
  logic [2:0] sel_idx;
  logic       commit;
  logic       seg_known;
  logic       seg_blank;
  logic [3:0] seg_code;

  // The FSM judges the incoming sample against the one captured last cycle, so the
  // counter reaches STABLE_CYCLES on the same edge that captures the last stable copy.
  assign sel_onehot  = (disp_io.digit_sel != '0) &&
                       ((disp_io.digit_sel & (disp_io.digit_sel - DIGITS'(1))) == '0);
  assign same_sample = (disp_io.digit_sel == samp_sel_q) && (disp_io.segments == samp_seg_q);

  always_comb begin
    sel_idx = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (disp_io.digit_sel[d]) begin
        sel_idx = 3'(d);
      end
    end
  end

  always_comb begin
    seg_known = 1'b1;
    seg_blank = 1'b0;
    seg_code  = 4'h0;
    case (disp_io.segments)
      7'b1000000: seg_code = 4'h0;
      7'b1111001: seg_code = 4'h1;
      7'b0100100: seg_code = 4'h2;
      7'b0110000: seg_code = 4'h3;
      7'b0011001: seg_code = 4'h4;
      7'b0010010: seg_code = 4'h5;
      7'b0000010: seg_code = 4'h6;
      7'b1111000: seg_code = 4'h7;
      7'b0000000: seg_code = 4'h8;
      7'b0010000: seg_code = 4'h9;
      7'b0001000: seg_code = 4'hA;
      7'b0000011: seg_code = 4'hB;
      7'b1000110: seg_code = 4'hC;
      7'b0100001: seg_code = 4'hD;
      7'b0000110: seg_code = 4'hE;
      7'b0001110: seg_code = 4'hF;
      7'b1111111: begin
        seg_known = 1'b0;
        seg_blank = 1'b1;
      end
      default: seg_known = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (!sel_onehot) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle:      cnt_d = CntOne;
        StSettling:  cnt_d = !same_sample ? CntOne :
                             (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
        StCommitted: cnt_d = same_sample ? cnt_q : CntOne;
        default:     cnt_d = '0;
      endcase
      if ((state_q == StCommitted) && same_sample) begin
        state_d = StCommitted;
      end else if (cnt_d == CntMax) begin
        state_d = StCommitted;
        commit  = 1'b1;
      end else begin
        state_d = StSettling;
      end
    end
  end

  always_comb begin
    values_d      = values_q;
    valid_d       = valid_q;
    update_d      = 1'b0;
    error_d       = 1'b0;
    error_digit_d = error_digit_q;
    if (commit) begin
      if (seg_known) begin
        for (int unsigned d = 0; d < DIGITS; d++) begin
          if (disp_io.digit_sel[d]) begin
            values_d[4*d +: 4] = seg_code;
            valid_d[d]         = 1'b1;
          end
        end
        update_d = (values_d != values_q) || (valid_d != valid_q);
      end else if (seg_blank) begin
        // Blank hides the digit but keeps its last value for when it lights again.
        for (int unsigned d = 0; d < DIGITS; d++) begin
          if (disp_io.digit_sel[d]) begin
            valid_d[d] = 1'b0;
          end
        end
        update_d = (valid_d != valid_q);
      end else begin
        error_d       = 1'b1;
        error_digit_d = sel_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      samp_sel_q    <= '0;
      samp_seg_q    <= 7'b1111111;
      values_q      <= '0;
      valid_q       <= '0;
      update_q      <= 1'b0;
      error_q       <= 1'b0;
      error_digit_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      samp_sel_q    <= disp_io.digit_sel;
      samp_seg_q    <= disp_io.segments;
      values_q      <= values_d;
      valid_q       <= valid_d;
      update_q      <= update_d;
      error_q       <= error_d;
      error_digit_q <= error_digit_d;
    end
  end

  assign disp_io.values      = values_q;
  assign disp_io.valid       = valid_q;
  assign disp_io.update      = update_q;
  assign disp_io.error       = error_q;
  assign disp_io.error_digit = error_digit_q;

endmodule
